// File: rtl/quad_nand_bist_pkg.sv
// rtl/quad_nand_bist_pkg.sv - shared constants and helpers for the quad NAND BIST
//
// Holds the sequencer state encodings, the step-index width, the error
// counter saturation value and the 2-input gate function used to build
// expected outputs.

package quad_nand_bist_pkg;

   // Sequencer states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DRIVE  = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_CHECK  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // Step index is {gate[1:0], vector[1:0]}
   localparam int                STEP_W    = 4;
   localparam logic [STEP_W-1:0] LAST_STEP = 4'd15;

   // err_count sticks here instead of wrapping
   localparam logic [3:0] ERR_SAT = 4'd15;

   // Function of the part under test; swap this for other quad 2-input parts
   function automatic logic gate_fn(input logic i_x, input logic i_y);
      return ~(i_x & i_y);
   endfunction

endpackage

// File: rtl/quad_nand_vector_gen.sv
// rtl/quad_nand_vector_gen.sv - combinational step-to-stimulus map for a quad 2-input part
//
// Ports:
//   i_step  [3:0] in   step index {gate, vector}
//   o_a     [3:0] out  A inputs for the step (bit0 = A1)
//   o_b     [3:0] out  B inputs for the step (bit0 = B1)
//   o_exp_y [3:0] out  expected Y outputs (bit0 = Y1)
//
// The gate under test gets A = vector[0], B = vector[1]; all other gates are
// parked at A = B = 1 so their outputs sit at the opposite level of an
// untested-but-idle NAND (0), which exposes crosstalk and bridging.

module quad_nand_vector_gen
   import quad_nand_bist_pkg::*;
(
   input  logic [3:0] i_step,
   output logic [3:0] o_a,
   output logic [3:0] o_b,
   output logic [3:0] o_exp_y
);

   logic [1:0] w_gate;
   logic       w_va;
   logic       w_vb;

   assign w_gate = i_step[3:2];
   assign w_va   = i_step[0];
   assign w_vb   = i_step[1];

   always_comb begin
      o_a     = 4'b1111;
      o_b     = 4'b1111;
      o_exp_y = 4'b0000;

      o_a[w_gate] = w_va;
      o_b[w_gate] = w_vb;

      // Parked gates see (1,1); their expected output is gate_fn(1,1)
      for (int i = 0; i < 4; i++) begin
         if (i[1:0] != w_gate) begin
            o_exp_y[i] = gate_fn(1'b1, 1'b1);
         end
      end
      o_exp_y[w_gate] = gate_fn(w_va, w_vb);
   end

endmodule

// File: rtl/quad_nand_bist.sv
// rtl/quad_nand_bist.sv - built-in self-test sequencer for a 7400 quad 2-input NAND
//
// Walks each of the four gates through all four input combinations, waits a
// programmable settle time, then compares all four outputs with the expected
// pattern. Reports pass/fail, first failing gate/vector and a saturating
// mismatch count.
//
// Parameters:
//   SETTLE_CYCLES  cycles between driving A/B and sampling Y (1..15)
//   STOP_ON_FAIL   1 = end the run at the first mismatch, 0 = run all 16 steps
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  synchronous, active-high
//   start      in   1  level; honoured only in IDLE or DONE
//   busy       out  1  high in DRIVE, SETTLE, CHECK
//   done       out  1  high in DONE
//   pass       out  1  valid while done; 1 = no mismatches
//   fail_gate  out  2  gate of the first mismatching step
//   fail_vec   out  2  vector of the first mismatching step
//   err_count  out  4  mismatching steps, saturating at 15
//   a          out  4  to A4..A1, registered
//   b          out  4  to B4..B1, registered
//   y          in   4  from Y4..Y1

module quad_nand_bist
   import quad_nand_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int STOP_ON_FAIL  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [1:0] fail_gate,
   output logic [1:0] fail_vec,
   output logic [3:0] err_count,
   output logic [3:0] a,
   output logic [3:0] b,
   input  logic [3:0] y
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
   localparam logic       STOP_EN     = (STOP_ON_FAIL != 0);

   logic [2:0]        r_state;
   logic [STEP_W-1:0] r_step;
   logic [3:0]        r_cnt;
   logic [3:0]        r_err;
   logic              r_pass;
   logic [1:0]        r_fail_gate;
   logic [1:0]        r_fail_vec;
   logic [3:0]        r_a;
   logic [3:0]        r_b;

   logic [3:0]        w_a;
   logic [3:0]        w_b;
   logic [3:0]        w_exp_y;
   logic              w_mismatch;
   logic [3:0]        w_err_next;
   logic              w_end_run;

   quad_nand_vector_gen u_vec (
      .i_step  (r_step),
      .o_a     (w_a),
      .o_b     (w_b),
      .o_exp_y (w_exp_y)
   );

   // Full 4-bit compare: parked gates must read 0 as well
   assign w_mismatch = (y != w_exp_y);

   assign w_err_next = !w_mismatch         ? r_err :
                       (r_err == ERR_SAT)  ? r_err :
                                             r_err + 4'd1;

   assign w_end_run  = (w_mismatch && STOP_EN) || (r_step == LAST_STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_step      <= '0;
         r_cnt       <= '0;
         r_err       <= '0;
         r_pass      <= 1'b0;
         r_fail_gate <= '0;
         r_fail_vec  <= '0;
         r_a         <= '0;
         r_b         <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_err       <= '0;
                  r_pass      <= 1'b0;
                  r_fail_gate <= '0;
                  r_fail_vec  <= '0;
                  r_step      <= '0;
                  r_state     <= ST_DRIVE;
               end
            end

            ST_DRIVE: begin
               r_a     <= w_a;
               r_b     <= w_b;
               r_cnt   <= SETTLE_LOAD;
               r_state <= ST_SETTLE;
            end

            // Exactly SETTLE_CYCLES cycles are spent here: leave on the
            // cycle the counter shows 1
            ST_SETTLE: begin
               if (r_cnt <= 4'd1) begin
                  r_state <= ST_CHECK;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end

            ST_CHECK: begin
               if (w_mismatch && (r_err == 4'd0)) begin
                  r_fail_gate <= r_step[3:2];
                  r_fail_vec  <= r_step[1:0];
               end
               r_err <= w_err_next;

               if (w_end_run) begin
                  r_a     <= '0;
                  r_b     <= '0;
                  r_pass  <= (w_err_next == 4'd0);
                  r_state <= ST_DONE;
               end else begin
                  r_step  <= r_step + 4'd1;
                  r_state <= ST_DRIVE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) || (r_state == ST_CHECK);
   assign done      = (r_state == ST_DONE);
   assign pass      = r_pass;
   assign fail_gate = r_fail_gate;
   assign fail_vec  = r_fail_vec;
   assign err_count = r_err;
   assign a         = r_a;
   assign b         = r_b;

endmodule
